// File: rtl/ring_seed_ctrl.sv
// ring_seed_ctrl: loads a duty-cycle pattern into a ring-counter clock divider
// through per-flop async preset/clear, then checks the ring's rotation every cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   en_i           enable ring operation (level)
//   seed_valid_i   new pattern offered on seed_i
//   seed_i         offered pattern
//   seed_ready_o   pattern accept qualifier (low while loading)
//   seed_rej_o     one-cycle pulse: offered pattern illegal, dropped
//   q_i            ring counter outputs fed back
//   pre_o, clr_o   per-flop async preset/clear to the ring, active-high
//   running_o      ring free-running and being checked
//   fault_o        sticky mismatch indication when auto-reload is off
//   err_cnt_o      saturating mismatch count
module ring_seed_ctrl #(
  parameter int unsigned       WIDTH        = 5,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = {1'b1, {(WIDTH-1){1'b0}}},
  parameter int unsigned       LOAD_CYCLES  = 2,
  parameter bit                AUTO_RELOAD  = 1'b1,
  parameter int unsigned       ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             seed_valid_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic             seed_ready_o,
  output logic             seed_rej_o,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] pre_o,
  output logic [WIDTH-1:0] clr_o,
  output logic             running_o,
  output logic             fault_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam int unsigned      CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FAULT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] clr_q, clr_d;
  logic             running_q, running_d;
  logic             fault_q, fault_d;
  logic             ready_q, ready_d;
  logic             rej_q, rej_d;

  logic seed_legal;
  logic accept;
  logic load_new;
  logic mismatch;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pat_q     <= DEFAULT_SEED;
      exp_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      pre_q     <= '0;
      clr_q     <= '1;
      running_q <= 1'b0;
      fault_q   <= 1'b0;
      ready_q   <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      pre_q     <= pre_d;
      clr_q     <= clr_d;
      running_q <= running_d;
      fault_q   <= fault_d;
      ready_q   <= ready_d;
      rej_q     <= rej_d;
    end
  end

  // Next-state, pattern/check bookkeeping, and outputs derived from the next state
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    exp_d     = exp_q;
    cnt_d     = '0;
    err_d     = err_q;
    pre_d     = '0;
    clr_d     = '0;
    running_d = 1'b0;
    fault_d   = 1'b0;
    ready_d   = 1'b1;
    rej_d     = 1'b0;

    // Legal iff popcount in 1..WIDTH-1, i.e. neither all-zero nor all-one
    seed_legal = (seed_i != '0) && (seed_i != '1);
    accept     = seed_valid_i && ready_q;
    load_new   = accept && seed_legal;
    mismatch   = (state_q == S_RUN) && (q_i != exp_q);

    if (accept && !seed_legal) rej_d = 1'b1;
    if (load_new)              pat_d = seed_i;
    if (mismatch && (err_q != '1)) err_d = err_q + ERR_W'(1);

    case (state_q)
      S_IDLE:  state_d = S_LOAD;
      S_LOAD: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_RUN;
          exp_d   = pat_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        exp_d = {exp_q[0], exp_q[WIDTH-1:1]};
        // A new legal seed always reloads, even when the mismatch would fault
        if (load_new || (mismatch && AUTO_RELOAD)) state_d = S_LOAD;
        else if (mismatch)                         state_d = S_FAULT;
      end
      S_FAULT: if (load_new) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase

    if (!en_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    case (state_d)
      S_LOAD: begin
        pre_d = pat_d;
        clr_d = ~pat_d;
      end
      S_RUN:   running_d = 1'b1;
      S_FAULT: begin
        clr_d   = '1;
        fault_d = 1'b1;
      end
      default: clr_d = '1;
    endcase
    ready_d = (state_d != S_LOAD);
  end

  assign seed_ready_o = ready_q;
  assign seed_rej_o   = rej_q;
  assign pre_o        = pre_q;
  assign clr_o        = clr_q;
  assign running_o    = running_q;
  assign fault_o      = fault_q;
  assign err_cnt_o    = err_q;

endmodule

// File: tb/tb_ring_seed_ctrl.sv
// tb_ring_seed_ctrl: two controllers (auto-reload on / off) driving behavioural
// ring counters; expected outputs come from a transaction-level model and are
// checked by a scoreboard monitor on the falling edge.
module tb_ring_seed_ctrl;

  localparam int unsigned W     = 5;
  localparam int unsigned ERR_W = 8;
  localparam int          LC    = 2;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_FAULT = 3;

  typedef struct packed {
    logic [W-1:0]     pre;
    logic [W-1:0]     clr;
    logic             running;
    logic             fault;
    logic             ready;
    logic             rej;
    logic [ERR_W-1:0] err;
  } obs_t;

  logic         clk;
  logic         rst_n;
  logic         en, sv, frc;
  logic [W-1:0] seed, fval;

  logic [W-1:0]     pre_w [2];
  logic [W-1:0]     clr_w [2];
  logic [W-1:0]     q_w   [2];
  logic             run_w [2];
  logic             flt_w [2];
  logic             rdy_w [2];
  logic             rej_w [2];
  logic [ERR_W-1:0] err_w [2];

  int errors = 0;
  int checks = 0;
  bit started = 0;
  obs_t sb0[$];
  obs_t sb1[$];

  // Reference model state
  int           mode [2];
  logic [W-1:0] pat [2];
  logic [W-1:0] run_pat [2];
  int           k [2];
  int           load_left [2];
  int           err [2];
  bit           rej [2];
  bit           rdy [2];
  bit           ar [2];

  ring_seed_ctrl #(.AUTO_RELOAD(1'b1)) u_ar (
    .clk(clk), .rst_n(rst_n), .en_i(en), .seed_valid_i(sv), .seed_i(seed),
    .seed_ready_o(rdy_w[0]), .seed_rej_o(rej_w[0]), .q_i(q_w[0]),
    .pre_o(pre_w[0]), .clr_o(clr_w[0]), .running_o(run_w[0]),
    .fault_o(flt_w[0]), .err_cnt_o(err_w[0])
  );

  ring_seed_ctrl #(.AUTO_RELOAD(1'b0)) u_ft (
    .clk(clk), .rst_n(rst_n), .en_i(en), .seed_valid_i(sv), .seed_i(seed),
    .seed_ready_o(rdy_w[1]), .seed_rej_o(rej_w[1]), .q_i(q_w[1]),
    .pre_o(pre_w[1]), .clr_o(clr_w[1]), .running_o(run_w[1]),
    .fault_o(flt_w[1]), .err_cnt_o(err_w[1])
  );

  // Behavioural ring counter: async preset/clear override, rotate right each edge
  for (genvar g = 0; g < 2; g++) begin : g_ring
    logic [W-1:0] ring;
    logic [W-1:0] q_eff;
    assign q_eff  = (ring & ~clr_w[g]) | pre_w[g];
    assign q_w[g] = frc ? fval : q_eff;
    always @(posedge clk)
      ring <= ((|pre_w[g]) || (|clr_w[g])) ? q_eff : {q_eff[0], q_eff[W-1:1]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] p, input int s);
    int sh;
    sh = s % W;
    if (sh == 0) return p;
    return W'((p >> sh) | (p << (W - sh)));
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pre=%b clr=%b run=%b flt=%b rdy=%b rej=%b err=%0d",
                     o.pre, o.clr, o.running, o.fault, o.ready, o.rej, o.err);
  endfunction

  function automatic obs_t actual(input int i);
    obs_t o;
    o.pre = pre_w[i]; o.clr = clr_w[i]; o.running = run_w[i]; o.fault = flt_w[i];
    o.ready = rdy_w[i]; o.rej = rej_w[i]; o.err = err_w[i];
    return o;
  endfunction

  function automatic obs_t expected(input int i);
    obs_t o;
    o.pre     = (mode[i] == M_LOAD) ? pat[i] : '0;
    o.clr     = (mode[i] == M_LOAD) ? ~pat[i] : ((mode[i] == M_RUN) ? '0 : '1);
    o.running = (mode[i] == M_RUN);
    o.fault   = (mode[i] == M_FAULT);
    o.ready   = rdy[i];
    o.rej     = rej[i];
    o.err     = ERR_W'(err[i]);
    return o;
  endfunction

  task automatic chk(input string nm, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %s, expected %s", nm, $time, fmt(a), fmt(e));
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_IDLE; pat[i] = 5'b10000; run_pat[i] = '0; k[i] = 0;
      load_left[i] = 0; err[i] = 0; rej[i] = 0; rdy[i] = 0;
    end
  endfunction

  // Advance one clock with the inputs that were applied during the cycle
  function automatic void model_step(input int i, input logic e, input logic v,
                                     input logic [W-1:0] s, input logic f,
                                     input logic [W-1:0] fv);
    bit acc, legal, mism, newp;
    int nm;
    acc   = v && rdy[i];
    legal = (s != '0) && (s != '1);
    newp  = acc && legal;
    mism  = (mode[i] == M_RUN) && f && (fv != rotr(run_pat[i], k[i]));
    if (mism && err[i] < ERR_MAX) err[i]++;
    rej[i] = acc && !legal;
    if (newp) pat[i] = s;
    nm = mode[i];
    if (!e) nm = M_IDLE;
    else begin
      case (mode[i])
        M_IDLE:  nm = M_LOAD;
        M_LOAD:  nm = (load_left[i] == 1) ? M_RUN : M_LOAD;
        M_RUN:   if (newp || (mism && ar[i])) nm = M_LOAD; else if (mism) nm = M_FAULT;
        M_FAULT: if (newp) nm = M_LOAD;
        default: nm = M_IDLE;
      endcase
    end
    if (nm == M_LOAD) load_left[i] = (mode[i] == M_LOAD) ? load_left[i] - 1 : LC;
    if (nm == M_RUN) begin
      if (mode[i] != M_RUN) begin run_pat[i] = pat[i]; k[i] = 0; end
      else k[i]++;
    end
    mode[i] = nm;
    rdy[i]  = (nm != M_LOAD);
  endfunction

  function automatic void push_exp();
    sb0.push_back(expected(0));
    sb1.push_back(expected(1));
  endfunction

  task automatic cyc(input logic e, input logic v, input logic [W-1:0] s,
                     input logic f, input logic [W-1:0] fv);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) model_step(i, en, sv, seed, frc, fval);
    push_exp();
    en = e; sv = v; seed = s; frc = f; fval = fv;
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) cyc(1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  // Assert reset away from the clock edge and check the async reset values
  task automatic do_reset(input logic e);
    obs_t r;
    r = '{pre: '0, clr: '1, running: 1'b0, fault: 1'b0, ready: 1'b0, rej: 1'b0, err: '0};
    #2;
    rst_n = 1'b0;
    sb0.delete(); sb1.delete();
    sv = 1'b0; frc = 1'b0;
    #1;
    chk("reset_ar", actual(0), r);
    chk("reset_ft", actual(1), r);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    push_exp();
    en = e;
    started = 1;
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && started) begin
        if (sb0.size() == 0 || sb1.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty @%0t: got no expectation, expected one per cycle", $time);
        end else begin
          chk("cycle_ar", actual(0), sb0.pop_front());
          chk("cycle_ft", actual(1), sb1.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ar[0] = 1'b1; ar[1] = 1'b0;
    en = 1'b0; sv = 1'b0; seed = '0; frc = 1'b0; fval = '0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset release with en=1, default pattern rotates cleanly
    do_reset(1'b1);
    idle_cycles(55);

    // New 40% pattern accepted in RUN
    cyc(1'b1, 1'b1, 5'b11000, 1'b0, '0);
    idle_cycles(25);

    // Illegal patterns are rejected
    cyc(1'b1, 1'b1, 5'b00000, 1'b0, '0);
    idle_cycles(3);
    cyc(1'b1, 1'b1, 5'b11111, 1'b0, '0);
    idle_cycles(8);

    // One corrupted RUN cycle: reload on one instance, fault on the other
    cyc(1'b1, 1'b0, '0, 1'b1, 5'b00000);
    idle_cycles(8);
    cyc(1'b0, 1'b0, '0, 1'b0, '0);
    idle_cycles(10);

    // en falling together with a seed accept
    cyc(1'b0, 1'b1, 5'b10100, 1'b0, '0);
    idle_cycles(8);

    // Mismatch together with a legal seed accept
    cyc(1'b1, 1'b1, 5'b01110, 1'b1, 5'b00001);
    idle_cycles(8);

    // Reset in the middle of LOAD, then in RUN
    do_reset(1'b1);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    do_reset(1'b1);
    idle_cycles(10);
    do_reset(1'b1);
    idle_cycles(5);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic e, v, f;
      logic [W-1:0] s, fv;
      e  = ($urandom_range(0, 19) != 0);
      v  = ($urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 3) == 0) ?
           (($urandom_range(0, 1) != 0) ? 5'b11111 : 5'b00000) : W'($urandom);
      f  = ($urandom_range(0, 15) == 0);
      fv = W'($urandom);
      cyc(e, v, s, f, fv);
    end

    // Sustained corruption drives the error counter into saturation
    for (int n = 0; n < 1000; n++) cyc(1'b1, 1'b0, '0, 1'b1, 5'b00000);
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    @(negedge clk); #1;
    checks++;
    if (err_w[0] !== ERR_W'(ERR_MAX)) begin
      errors++;
      $display("FAIL err_saturate: got %0d, expected %0d", err_w[0], ERR_MAX);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
